rom_copier: RTL and testbench



---
 rtl/rom_copier.sv | 144 ++++++++++++++
 tb/tb_rom_copier.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rom_copier.sv
// rom_copier: boot-time shadow copier from the synchronous ROM into RAM.
// It holds the CPU in reset until the first copy is done. Defining ROM_COPY_SUM_EN adds the `sum` checksum port.

module rom_copier #(
    parameter int KB = 16,
    parameter int RW = 18,
    parameter logic [RW-1:0] BASE = '0,
    localparam int AW = $clog2(KB*1024)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] romA,
    input  logic [7:0]    romQ,
    output logic [RW-1:0] ramA,
    output logic [7:0]    ramD,
    output logic          ramW,
    input  logic          ramAck,
    output logic          busy,
    output logic          cpuReset
`ifdef ROM_COPY_SUM_EN
    ,
    output logic [7:0]    sum
`endif
);

    localparam logic [AW-1:0] LAST = AW'(KB*1024-1);

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, NEXT, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] ramA_q, ramA_d;
    logic [7:0]    ramD_q, ramD_d;
    logic          ramW_q, ramW_d;
    logic          busy_q, busy_d;
    logic          cpuRst_q, cpuRst_d;
`ifdef ROM_COPY_SUM_EN
    logic [7:0]    sum_q, sum_d;
`endif

    function automatic logic [RW-1:0] ram_addr(input logic [AW-1:0] c);
        return BASE + RW'(c);
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ramA_q   <= BASE;
            ramD_q   <= '0;
            ramW_q   <= 1'b0;
            busy_q   <= 1'b0;
            cpuRst_q <= 1'b0;
`ifdef ROM_COPY_SUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ramA_q   <= ramA_d;
            ramD_q   <= ramD_d;
            ramW_q   <= ramW_d;
            busy_q   <= busy_d;
            cpuRst_q <= cpuRst_d;
`ifdef ROM_COPY_SUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ramA_d   = ramA_q;
        ramD_d   = ramD_q;
        ramW_d   = ramW_q;
        busy_d   = busy_q;
        cpuRst_d = cpuRst_q;
`ifdef ROM_COPY_SUM_EN
        sum_d    = sum_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = READ;
                busy_d  = 1'b1;
                cnt_d   = '0;
`ifdef ROM_COPY_SUM_EN
                sum_d   = '0;
`endif
            end
            READ: state_d = WAIT;
            // romA has been stable since READ began, so romQ now belongs to cnt_q
            WAIT: begin
                ramD_d  = romQ;
                ramA_d  = ram_addr(cnt_q);
                ramW_d  = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                if (ramAck) begin
                    ramW_d  = 1'b0;
                    state_d = NEXT;
`ifdef ROM_COPY_SUM_EN
                    sum_d   = sum_q + ramD_q;
`endif
                end
            end
            NEXT: begin
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    busy_d   = 1'b0;
                    cpuRst_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + AW'(1);
                    state_d = READ;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = READ;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
`ifdef ROM_COPY_SUM_EN
                    sum_d   = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The counter only moves on entry to READ, which keeps the ROM address constant through WAIT.
    assign romA     = cnt_q;
    assign ramA     = ramA_q;
    assign ramD     = ramD_q;
    assign ramW     = ramW_q;
    assign busy     = busy_q;
    assign cpuReset = cpuRst_q;
`ifdef ROM_COPY_SUM_EN
    assign sum      = sum_q;
`endif

endmodule

// File: tb/tb_rom_copier.sv
// Bench for rom_copier: a 1 KiB ROM copied to BASE 0x100, with a second instance checking RAM address wrap (RW=10, BASE=0x3FF).
// Each copy run comes from a table of scenarios. Hand-written sequences cover the reset state and an abort in mid-copy.

module tb_rom_copier;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start;
    logic [9:0]  romA;
    logic [7:0]  romQ;
    logic [17:0] ramA;
    logic [7:0]  ramD;
    logic        ramW, ramAck, busy, cpuReset;
    logic [9:0]  romA2;
    logic [7:0]  romQ2;
    logic [9:0]  ramA2;
    logic [7:0]  ramD2;
    logic        ramW2, ramAck2, busy2, cpuReset2;
`ifdef ROM_COPY_SUM_EN
    logic [7:0]  sum, sum2;
`endif

    rom_copier #(.KB(1), .RW(18), .BASE(18'h100)) u_dut (
        .clock(clk), .reset(rst_n), .start(start),
        .romA(romA), .romQ(romQ), .ramA(ramA), .ramD(ramD),
        .ramW(ramW), .ramAck(ramAck), .busy(busy), .cpuReset(cpuReset)
`ifdef ROM_COPY_SUM_EN
        , .sum(sum)
`endif
    );

    rom_copier #(.KB(1), .RW(10), .BASE(10'h3FF)) u_wrap (
        .clock(clk), .reset(rst_n), .start(start),
        .romA(romA2), .romQ(romQ2), .ramA(ramA2), .ramD(ramD2),
        .ramW(ramW2), .ramAck(ramAck2), .busy(busy2), .cpuReset(cpuReset2)
`ifdef ROM_COPY_SUM_EN
        , .sum(sum2)
`endif
    );

    // ROM images hold addr[7:0]; one clock read latency
    always @(posedge clk) begin
        romQ  <= romA[7:0];
        romQ2 <= romA2[7:0];
    end

    int          stall_byte, stall_cycles, stall;
    logic [17:0] stall_addr;
    logic        spur_en;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)              stall <= 0;
        else if (ramW && ramAck) stall <= 0;
        else if (ramW)           stall <= stall + 1;
    end

    // spur_en drives ramAck whenever no write is pending (READ/WAIT/NEXT)
    assign ramAck  = ramW ? ((ramA == stall_addr) ? (stall >= stall_cycles) : 1'b1) : spur_en;
    assign ramAck2 = ramW2;

    logic [17:0] wa[$];
    logic [7:0]  wd[$];
    logic [9:0]  wa2[$];
    int          held, held_bad;

    always @(negedge clk) begin
        if (rst_n && ramW && ramAck) begin
            wa.push_back(ramA);
            wd.push_back(ramD);
        end
        if (rst_n && ramW2 && ramAck2) wa2.push_back(ramA2);
        if (rst_n && ramW && ramA == stall_addr) begin
            held <= held + 1;
            if (ramD != stall_byte[7:0]) held_bad <= held_bad + 1;
        end
    end

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic wait_done(input bit mid, output int n, output int low);
        n = 0;
        low = 0;
        for (int c = 0; c < 6000; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            n++;
            if (mid && n == 2000) start = 1'b1;
            if (!cpuReset) low++;
            if (!busy) break;
        end
    endtask

    typedef struct {
        int sb;
        int sc;
        bit spur;
        bit via_start;
        bit mid;
        int exp_cycles;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int n, low, bad;
        vec_t v;
        rst_n = 1'b0; start = 1'b0; spur_en = 1'b0;
        stall_byte = 5; stall_cycles = 0; stall_addr = 18'h105;
        held = 0; held_bad = 0;

        vecs[0] = '{5, 0, 1'b0, 1'b0, 1'b0, 4097};  // zero-wait copy from reset
        vecs[1] = '{5, 3, 1'b0, 1'b1, 1'b0, 4100};  // byte 5 stalled 3 cycles, re-copy by start
        vecs[2] = '{5, 0, 1'b1, 1'b1, 1'b1, 4097};  // spurious acks + start mid-copy ignored
        vecs[3] = '{0, 1, 1'b1, 1'b0, 1'b0, 4098};  // byte 0 stalled 1, spurious acks, from reset

        repeat (3) @(posedge clk);
        #1;
        chk("rst_romA", romA, 0);
        chk("rst_ramA", ramA, 18'h100);
        chk("rst_ramD", ramD, 0);
        chk("rst_ramW", ramW, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cpuReset", cpuReset, 0);
        chk("rst_wrap_ramA", ramA2, 10'h3FF);
`ifdef ROM_COPY_SUM_EN
        chk("rst_sum", sum, 0);
`endif

        // abort in mid-copy, right after byte 100 is accepted
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (wa.size() >= 101) break;
        end
        chk("abort_writes_before", wa.size(), 101);
        chk("abort_busy_before", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_ramW", ramW, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cpuReset", cpuReset, 0);
        chk("abort_romA", romA, 0);
        chk("abort_ramA", ramA, 18'h100);

        for (int k = 0; k < 4; k++) begin
            v = vecs[k];
            stall_byte = v.sb;
            stall_cycles = v.sc;
            stall_addr = 18'(32'h100 + v.sb);
            spur_en = v.spur;
            held = 0; held_bad = 0;
            wa.delete(); wd.delete(); wa2.delete();
            if (v.via_start) start = 1'b1;
            else begin
                rst_n = 1'b0;
                @(negedge clk) rst_n = 1'b1;
            end
            wait_done(v.mid, n, low);
            spur_en = 1'b0;

            chk($sformatf("v%0d_cycles", k), n, v.exp_cycles);
            chk($sformatf("v%0d_cpuReset_low_cycles", k), low, v.via_start ? 0 : v.exp_cycles - 1);
            chk($sformatf("v%0d_cpuReset_end", k), cpuReset, 1);
            chk($sformatf("v%0d_ramW_end", k), ramW, 0);
            chk($sformatf("v%0d_writes", k), wa.size(), 1024);
            bad = 0;
            for (int i = 0; i < wa.size(); i++)
                if (wa[i] !== 18'(32'h100 + i) || wd[i] !== i[7:0]) bad++;
            chk($sformatf("v%0d_ram_contents_bad", k), bad, 0);
            chk($sformatf("v%0d_held_cycles", k), held, v.sc + 1);
            chk($sformatf("v%0d_held_data_bad", k), held_bad, 0);
            chk($sformatf("v%0d_wrap_writes", k), wa2.size(), 1024);
            chk($sformatf("v%0d_wrap_first", k), (wa2.size() > 0) ? wa2[0] : 'x, 10'h3FF);
            chk($sformatf("v%0d_wrap_second", k), (wa2.size() > 1) ? wa2[1] : 'x, 10'h000);
            chk($sformatf("v%0d_wrap_last", k), (wa2.size() > 0) ? wa2[wa2.size()-1] : 'x, 10'h3FE);
            chk($sformatf("v%0d_wrap_cpuReset", k), cpuReset2, 1);
`ifdef ROM_COPY_SUM_EN
            chk($sformatf("v%0d_sum", k), sum, 0);
            chk($sformatf("v%0d_wrap_sum", k), sum2, 0);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
